// File: rtl/program_loader.sv
// Program loader: fills the 16-byte program RAM from pin strobes, then releases the CPU core.
// Define LOADER_CHECKSUM_EN to require a trailing checksum byte after a full load.
module program_loader #(
  parameter int unsigned RAM_BYTES = 16,
  parameter int unsigned ADDR_W    = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [7:0]        ext_data_i,
  input  logic              ext_strobe_i,
  input  logic              ext_load_i,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [7:0]        ram_data_o,
  output logic              ram_we_o,
  output logic              cpu_rst_n_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              error_o,
  output logic [ADDR_W:0]   byte_count_o
);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StLoad  = 3'd1;
  localparam logic [2:0] StWrite = 3'd2;
  localparam logic [2:0] StRun   = 3'd3;
`ifdef LOADER_CHECKSUM_EN
  localparam logic [2:0] StCheck = 3'd4;
  localparam logic [2:0] StError = 3'd5;
`endif

  localparam logic [ADDR_W:0] FullCount = (ADDR_W + 1)'(RAM_BYTES);

  logic              strobe_meta_q, strobe_sync_q, strobe_prev_q;
  logic              load_meta_q, load_sync_q, load_prev_q;
  logic              str_edge, ld_edge;

  logic [2:0]        state_q, state_d;
  logic [ADDR_W:0]   count_q, count_d, count_inc;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        data_q, data_d;
  logic              we_q, busy_q, busy_d, done_q, cpu_rst_n_q;

`ifdef LOADER_CHECKSUM_EN
  logic [7:0]        sum_q, sum_d, check_sum;
  logic              error_q;
  assign check_sum = sum_q + ext_data_i;
`endif

  assign str_edge  = strobe_sync_q & ~strobe_prev_q;
  assign ld_edge   = load_sync_q & ~load_prev_q;
  assign count_inc = (count_q == FullCount) ? count_q : count_q + 1'b1;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    addr_d  = addr_q;
    data_d  = data_q;
`ifdef LOADER_CHECKSUM_EN
    sum_d   = sum_q;
`endif
    case (state_q)
      StIdle: begin
        if (load_sync_q) begin
          state_d = StLoad;
          count_d = '0;
`ifdef LOADER_CHECKSUM_EN
          sum_d   = '0;
`endif
        end else if (str_edge) begin
          state_d = StRun;
        end
      end
      StLoad: begin
        // A captured byte wins over a load drop seen in the same cycle.
        if (str_edge) begin
          data_d  = ext_data_i;
          addr_d  = count_q[ADDR_W-1:0];
          state_d = StWrite;
`ifdef LOADER_CHECKSUM_EN
          sum_d   = sum_q + ext_data_i;
`endif
        end else if (!load_sync_q) begin
`ifdef LOADER_CHECKSUM_EN
          state_d = StError;
`else
          state_d = StRun;
`endif
        end
      end
      StWrite: begin
        count_d = count_inc;
        if (count_inc == FullCount) begin
`ifdef LOADER_CHECKSUM_EN
          state_d = StCheck;
`else
          state_d = StRun;
`endif
        end else begin
          state_d = StLoad;
        end
      end
      StRun: begin
        if (ld_edge) begin
          state_d = StLoad;
          count_d = '0;
`ifdef LOADER_CHECKSUM_EN
          sum_d   = '0;
`endif
        end
      end
`ifdef LOADER_CHECKSUM_EN
      StCheck: begin
        if (str_edge) begin
          state_d = (check_sum == 8'h00) ? StRun : StError;
        end
      end
      StError: begin
        if (ld_edge) begin
          state_d = StLoad;
          count_d = '0;
          sum_d   = '0;
        end
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy_d = (state_d == StLoad) || (state_d == StWrite);
`ifdef LOADER_CHECKSUM_EN
    busy_d = busy_d || (state_d == StCheck);
`endif
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      strobe_meta_q <= 1'b0;
      strobe_sync_q <= 1'b0;
      strobe_prev_q <= 1'b0;
      load_meta_q   <= 1'b0;
      load_sync_q   <= 1'b0;
      load_prev_q   <= 1'b0;
      state_q       <= StIdle;
      count_q       <= '0;
      addr_q        <= '0;
      data_q        <= '0;
      we_q          <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      cpu_rst_n_q   <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      sum_q         <= '0;
      error_q       <= 1'b0;
`endif
    end else begin
      strobe_meta_q <= ext_strobe_i;
      strobe_sync_q <= strobe_meta_q;
      strobe_prev_q <= strobe_sync_q;
      load_meta_q   <= ext_load_i;
      load_sync_q   <= load_meta_q;
      load_prev_q   <= load_sync_q;
      state_q       <= state_d;
      count_q       <= count_d;
      addr_q        <= addr_d;
      data_q        <= data_d;
      we_q          <= (state_d == StWrite);
      busy_q        <= busy_d;
      done_q        <= (state_d == StRun);
      cpu_rst_n_q   <= (state_d == StRun);
`ifdef LOADER_CHECKSUM_EN
      sum_q         <= sum_d;
      error_q       <= (state_d == StError);
`endif
    end
  end

  assign ram_addr_o   = addr_q;
  assign ram_data_o   = data_q;
  assign ram_we_o     = we_q;
  assign cpu_rst_n_o  = cpu_rst_n_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign byte_count_o = count_q;
`ifdef LOADER_CHECKSUM_EN
  assign error_o      = error_q;
`else
  assign error_o      = 1'b0;
`endif

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: full/early loads, reload, strobe hygiene, mid-load reset,
// and checksum acceptance/rejection when LOADER_CHECKSUM_EN is defined.
module tb_program_loader;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] ext_data;
  logic       ext_strobe;
  logic       ext_load;
  logic [3:0] ram_addr;
  logic [7:0] ram_data;
  logic       ram_we;
  logic       cpu_rst_n;
  logic       busy;
  logic       done;
  logic       error;
  logic [4:0] byte_count;

  int total = 0;
  int bad   = 0;

  // Write monitor: model RAM, write log and pulse-width watch, sampled on the falling edge.
  logic [7:0] mem_model [16];
  logic [3:0] log_addr [256];
  int         we_cnt     = 0;
  int         long_pulse = 0;
  logic       we_prev    = 1'b0;
  int         base;

  always #5 clk = ~clk;

  program_loader #(.RAM_BYTES(16), .ADDR_W(4)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .ext_data_i   (ext_data),
    .ext_strobe_i (ext_strobe),
    .ext_load_i   (ext_load),
    .ram_addr_o   (ram_addr),
    .ram_data_o   (ram_data),
    .ram_we_o     (ram_we),
    .cpu_rst_n_o  (cpu_rst_n),
    .busy_o       (busy),
    .done_o       (done),
    .error_o      (error),
    .byte_count_o (byte_count)
  );

  always @(negedge clk) begin
    if (ram_we === 1'b1) begin
      mem_model[ram_addr] = ram_data;
      if (we_cnt < 256) log_addr[we_cnt] = ram_addr;
      we_cnt = we_cnt + 1;
      if (we_prev) long_pulse = long_pulse + 1;
    end
    we_prev = (ram_we === 1'b1);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic strobe(input logic [7:0] d);
    ext_data   = d;
    ext_strobe = 1'b1;
    tick(4);
    ext_strobe = 1'b0;
    tick(4);
  endtask

  initial begin
    rst = 1'b1; ext_data = 8'h00; ext_strobe = 1'b0; ext_load = 1'b0;
    tick(3);
    rst = 1'b0;
    tick(1);

    // Reset state
    chk("rst_cpu_rst_n", cpu_rst_n, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_we", ram_we, 0);
    chk("rst_count", byte_count, 0);
    chk("rst_addr", ram_addr, 0);
    chk("rst_data", ram_data, 0);

    // Run without load: strobe from IDLE goes straight to RUN
    strobe(8'h55);
    chk("nl_writes", we_cnt, 0);
    chk("nl_done", done, 1);
    chk("nl_cpu_rst_n", cpu_rst_n, 1);
    chk("nl_busy", busy, 0);

    // Reload request from RUN acts within 3 clk
    ext_load = 1'b1;
    tick(3);
    chk("rl_cpu_rst_n", cpu_rst_n, 0);
    chk("rl_count", byte_count, 0);
    chk("rl_busy", busy, 1);
    chk("rl_done", done, 0);

    // Full load 0x10..0x1F
    base = we_cnt;
    for (int i = 0; i < 15; i++) strobe(8'h10 + 8'(i));
    ext_data   = 8'h1F;
    ext_strobe = 1'b1;
    tick(3);
    chk("fl_last_we", ram_we, 1);
    chk("fl_last_addr", ram_addr, 4'hF);
    chk("fl_last_data", ram_data, 8'h1F);
    chk("fl_last_done_early", done, 0);
    tick(1);
    chk("fl_we_drop", ram_we, 0);
    chk("fl_count16", byte_count, 16);
`ifdef LOADER_CHECKSUM_EN
    chk("fl_check_busy", busy, 1);
    chk("fl_check_done", done, 0);
    ext_strobe = 1'b0;
    tick(4);
    ext_load = 1'b0;
    strobe(8'h88);
`else
    chk("fl_done_next", done, 1);
    chk("fl_cpu_next", cpu_rst_n, 1);
    ext_strobe = 1'b0;
    tick(4);
    ext_load = 1'b0;
    tick(4);
`endif
    chk("fl_writes", we_cnt - base, 16);
    chk("fl_first_addr", log_addr[base], 0);
    for (int i = 0; i < 16; i++) chk($sformatf("fl_mem%0d", i), mem_model[i], 8'h10 + 8'(i));
    chk("fl_done", done, 1);
    chk("fl_cpu_rst_n", cpu_rst_n, 1);
    chk("fl_error", error, 0);
    chk("fl_addr_hold", ram_addr, 4'hF);
    chk("fl_data_hold", ram_data, 8'h1F);

    // Strobes in RUN are ignored
    base = we_cnt;
    strobe(8'h99);
    strobe(8'h9A);
    chk("run_strobe_writes", we_cnt - base, 0);
    chk("run_strobe_done", done, 1);

    // Early termination after 5 bytes
    ext_load = 1'b1;
    tick(3);
    base = we_cnt;
    for (int i = 0; i < 5; i++) strobe(8'hA0 + 8'(i));
    ext_load = 1'b0;
    tick(4);
    chk("et_writes", we_cnt - base, 5);
    chk("et_first_addr", log_addr[base], 0);
    chk("et_last_addr", log_addr[base+4], 4);
    chk("et_mem4", mem_model[4], 8'hA4);
    chk("et_mem5_kept", mem_model[5], 8'h15);
    chk("et_count", byte_count, 5);
    chk("et_busy", busy, 0);
`ifdef LOADER_CHECKSUM_EN
    chk("et_error", error, 1);
    chk("et_done", done, 0);
    chk("et_cpu_rst_n", cpu_rst_n, 0);
`else
    chk("et_done", done, 1);
    chk("et_cpu_rst_n", cpu_rst_n, 1);
    chk("et_error", error, 0);
`endif

    // Strobe held high 10 clk yields one write
    ext_load = 1'b1;
    tick(3);
    chk("sh_busy", busy, 1);
    chk("sh_count0", byte_count, 0);
    chk("sh_error_clr", error, 0);
    base = we_cnt;
    ext_data   = 8'h5A;
    ext_strobe = 1'b1;
    tick(10);
    ext_strobe = 1'b0;
    tick(4);
    chk("sh_writes", we_cnt - base, 1);
    chk("sh_count", byte_count, 1);
    chk("sh_mem0", mem_model[0], 8'h5A);

    // Reset mid-load after 7 bytes
    for (int i = 0; i < 6; i++) strobe(8'h61 + 8'(i));
    chk("rm_count7", byte_count, 7);
    chk("rm_mem6", mem_model[6], 8'h66);
    rst = 1'b1;
    ext_load = 1'b0;
    tick(1);
    rst = 1'b0;
    chk("rm_cpu_rst_n", cpu_rst_n, 0);
    chk("rm_busy", busy, 0);
    chk("rm_done", done, 0);
    chk("rm_error", error, 0);
    chk("rm_we", ram_we, 0);
    chk("rm_count", byte_count, 0);
    chk("rm_addr", ram_addr, 0);
    chk("rm_data", ram_data, 0);
    base = we_cnt;
    tick(10);
    chk("rm_no_writes", we_cnt - base, 0);
    chk("rm_idle_busy", busy, 0);

`ifdef LOADER_CHECKSUM_EN
    // Good checksum: sum(0x01..0x10)=0x88, 0x88+0x78=0x100
    ext_load = 1'b1;
    tick(3);
    for (int i = 1; i <= 16; i++) strobe(8'(i));
    ext_load = 1'b0;
    base = we_cnt;
    strobe(8'h78);
    chk("cs_ok_no_write", we_cnt - base, 0);
    chk("cs_ok_done", done, 1);
    chk("cs_ok_error", error, 0);
    chk("cs_ok_cpu", cpu_rst_n, 1);
    chk("cs_ok_mem15", mem_model[15], 8'h10);

    // Bad checksum
    ext_load = 1'b1;
    tick(3);
    for (int i = 1; i <= 16; i++) strobe(8'(i));
    ext_load = 1'b0;
    strobe(8'h77);
    chk("cs_bad_error", error, 1);
    chk("cs_bad_cpu", cpu_rst_n, 0);
    chk("cs_bad_done", done, 0);

    // Reload clears the error
    ext_load = 1'b1;
    tick(3);
    chk("cs_rl_error", error, 0);
    chk("cs_rl_busy", busy, 1);
    ext_load = 1'b0;
    tick(4);
`endif

    chk("we_single_cycle", long_pulse, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
